// File: rtl/beat_gen_pkg.sv
// Shared constants for the beat generator: FSM state encoding and one-hot beat codes.
package beat_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // W1 lives in bit 0 so {W3,W2,W1} maps straight onto the beat register
  localparam logic [2:0] BEAT_NONE = 3'b000;
  localparam logic [2:0] BEAT_W1   = 3'b001;
  localparam logic [2:0] BEAT_W2   = 3'b010;
  localparam logic [2:0] BEAT_W3   = 3'b100;

endpackage

// File: rtl/beat_gen_if.sv
// Front-panel, controller-request and beat-output bundle of beat_gen.
interface beat_gen_if;
  logic        QD;
  logic        DP;
  logic        SHORT;
  logic        LONG;
  logic        STOP;
  logic        W1;
  logic        W2;
  logic        W3;
  logic        RUN;
  logic [15:0] CYC;

  modport slave  (input  QD, DP, SHORT, LONG, STOP,
                  output W1, W2, W3, RUN, CYC);
  modport master (output QD, DP, SHORT, LONG, STOP,
                  input  W1, W2, W3, RUN, CYC);
endinterface

// File: rtl/beat_gen_qd_sync.sv
// Two-flop synchronizer for a front-panel level; EDGE_EN adds a one-cycle rising-edge pulse.
module qd_sync #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise
);

  logic r_s1, r_s2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_lvl = r_s2;

  generate
    if (EDGE_EN) begin : g_edge
      logic r_s3;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_s3 <= 1'b0;
        else          r_s3 <= r_s2;
      end
      assign o_rise = r_s2 & ~r_s3;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/beat_gen.sv
// Beat (machine-cycle) generator: one-hot W1/W2/W3 with SHORT/LONG/STOP and QD/DP stepping.
// Optional completed-cycle counter on CYC when BEATGEN_CYCLE_CNT_EN is defined.
module beat_gen
  import beat_pkg::*;
(
  input  logic      T3,
  input  logic      CLR,
  beat_gen_if.slave bus
);

  state_t     r_state, w_next_state;
  logic [2:0] r_beat, w_next_beat;
  logic       w_cyc_end;
  logic       w_qd_rise, w_qd_lvl;
  logic       w_dp, w_dp_rise;
  logic       w_unused;

  qd_sync #(.EDGE_EN(1'b1)) u_qd_sync (
    .i_clk(T3), .i_rst_n(CLR), .i_d(bus.QD), .o_lvl(w_qd_lvl), .o_rise(w_qd_rise)
  );

  qd_sync #(.EDGE_EN(1'b0)) u_dp_sync (
    .i_clk(T3), .i_rst_n(CLR), .i_d(bus.DP), .o_lvl(w_dp), .o_rise(w_dp_rise)
  );

  assign w_unused = w_qd_lvl ^ w_dp_rise;

  always_ff @(posedge T3) begin
    if (!CLR) begin
      r_state <= ST_IDLE;
      r_beat  <= BEAT_NONE;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_next_beat;
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    w_next_beat  = BEAT_NONE;
    w_cyc_end    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_qd_rise) begin
          w_next_state = ST_RUN;
          w_next_beat  = BEAT_W1;
        end
      end
      ST_RUN: begin
        // Cycle end is judged independently of STOP so a stop on the last beat still counts
        case (r_beat)
          BEAT_W1: w_cyc_end = bus.SHORT;
          BEAT_W2: w_cyc_end = ~bus.LONG;
          BEAT_W3: w_cyc_end = 1'b1;
          default: w_cyc_end = 1'b0;
        endcase
        if (r_beat == BEAT_W1 || r_beat == BEAT_W2 || r_beat == BEAT_W3) begin
          if (!bus.STOP && !(w_cyc_end && w_dp)) begin
            w_next_state = ST_RUN;
            if (w_cyc_end)              w_next_beat = BEAT_W1;
            else if (r_beat == BEAT_W1) w_next_beat = BEAT_W2;
            else                        w_next_beat = BEAT_W3;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_beat  = BEAT_NONE;
      end
    endcase
  end

  assign bus.W1  = r_beat[0];
  assign bus.W2  = r_beat[1];
  assign bus.W3  = r_beat[2];
  assign bus.RUN = (r_state == ST_RUN);

`ifdef BEATGEN_CYCLE_CNT_EN
  logic [15:0] r_cyc;

  always_ff @(posedge T3) begin
    if (!CLR)           r_cyc <= 16'h0000;
    else if (w_cyc_end) r_cyc <= r_cyc + 16'd1;
  end

  assign bus.CYC = r_cyc;
`else
  assign bus.CYC = 16'h0000;
`endif

endmodule

// File: tb/tb_beat_gen.sv
// Directed bench for beat_gen: per-cycle compare against a phase/count model plus literal pins.
module tb_beat_gen;

`ifdef BEATGEN_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic T3, CLR;
  beat_gen_if bif();

  beat_gen u_dut (.T3(T3), .CLR(CLR), .bus(bif));

  initial T3 = 1'b0;
  always #5 T3 = ~T3;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: beat phase 0 = idle, 1..3 = W1..W3; synchronizer delay expressed as a pin history
  int          m_beat = 0;
  int unsigned m_cyc  = 0;
  bit qh1, qh2, qh3, dh1, dh2;

  always @(posedge T3) begin
    bit rise, ends;
    int nb;
    if (!CLR) begin
      m_beat = 0; m_cyc = 0;
      qh1 = 0; qh2 = 0; qh3 = 0; dh1 = 0; dh2 = 0;
    end else begin
      rise = qh2 && !qh3;
      ends = 1'b0;
      nb   = m_beat;
      if (m_beat == 0) begin
        if (rise) nb = 1;
      end else begin
        ends = (m_beat == 1 && bif.SHORT) || (m_beat == 2 && !bif.LONG) || (m_beat == 3);
        if (bif.STOP)  nb = 0;
        else if (ends) nb = dh2 ? 0 : 1;
        else           nb = m_beat + 1;
      end
      if (ends && CNT_EN) m_cyc = (m_cyc + 1) % 65536;
      qh3 = qh2; qh2 = qh1; qh1 = bif.QD;
      dh2 = dh1; dh1 = bif.DP;
      m_beat = nb;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge T3) begin
    if (chk_en) begin
      check("model_W", {29'd0, bif.W3, bif.W2, bif.W1},
            (m_beat == 0) ? 32'd0 : (32'd1 << (m_beat - 1)));
      check("model_RUN", {31'd0, bif.RUN}, {31'd0, (m_beat != 0)});
      check("model_CYC", {16'd0, bif.CYC}, m_cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge T3);
  endtask

  function automatic logic [31:0] cexp(input int v);
    return CNT_EN ? v : 0;
  endfunction

  function automatic logic [31:0] wv();
    return {29'd0, bif.W3, bif.W2, bif.W1};
  endfunction

  initial begin
    CLR = 1'b0;
    bif.QD = 0; bif.DP = 0; bif.SHORT = 0; bif.LONG = 0; bif.STOP = 0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    CLR = 1'b1;
    tick(1);
    check("reset_W", wv(), 32'd0);
    check("reset_RUN", {31'd0, bif.RUN}, 32'd0);
    check("reset_CYC", {16'd0, bif.CYC}, 32'd0);

    // Start: W1 exactly on the third edge after the QD rise
    bif.QD = 1;
    tick(2);
    check("qd_lat_2edges", wv(), 32'd0);
    tick(1);
    check("qd_lat_3edges", wv(), 32'd1);
    bif.QD = 0;
    tick(4);
    check("normal_W", wv(), 32'd1);
    check("normal_CYC", {16'd0, bif.CYC}, cexp(2));

    bif.SHORT = 1;
    tick(3);
    check("short_W", wv(), 32'd1);
    check("short_CYC", {16'd0, bif.CYC}, cexp(5));

    bif.SHORT = 0; bif.LONG = 1;
    tick(1);
    check("long_W2", wv(), 32'd2);
    tick(1);
    check("long_W3", wv(), 32'd4);
    bif.LONG = 0;
    tick(1);
    check("long_back_W1", wv(), 32'd1);
    check("long_CYC", {16'd0, bif.CYC}, cexp(6));

    bif.SHORT = 1; bif.LONG = 1;
    tick(1);
    check("short_wins_W", wv(), 32'd1);
    check("short_wins_CYC", {16'd0, bif.CYC}, cexp(7));
    bif.SHORT = 0; bif.LONG = 0;

    bif.STOP = 1;
    tick(1);
    check("stop_W", wv(), 32'd0);
    check("stop_RUN", {31'd0, bif.RUN}, 32'd0);
    check("stop_midcycle_CYC", {16'd0, bif.CYC}, cexp(7));
    bif.STOP = 0;

    bif.QD = 1;
    tick(3);
    check("resume_W1", wv(), 32'd1);
    bif.QD = 0;
    tick(2);
    bif.QD = 1;
    tick(1);
    bif.QD = 0;
    tick(4);
    check("qd_in_run_RUN", {31'd0, bif.RUN}, 32'd1);
    check("qd_in_run_W", wv(), 32'd2);

    // Single step: DP reaches the FSM two edges after it is set
    bif.DP = 1;
    tick(3);
    check("dp_idle_W", wv(), 32'd0);
    check("dp_idle_CYC", {16'd0, bif.CYC}, cexp(12));
    bif.QD = 1;
    tick(3);
    check("step_W1", wv(), 32'd1);
    bif.QD = 0;
    tick(1);
    check("step_W2", wv(), 32'd2);
    tick(1);
    check("step_end_W", wv(), 32'd0);
    check("step_CYC", {16'd0, bif.CYC}, cexp(13));

    bif.QD = 1;
    tick(3);
    bif.QD = 0;
    bif.STOP = 1; bif.SHORT = 1;
    tick(1);
    check("stop_dp_W", wv(), 32'd0);
    check("stop_dp_CYC", {16'd0, bif.CYC}, cexp(14));
    bif.STOP = 0; bif.SHORT = 0; bif.DP = 0;
    tick(3);

    bif.QD = 1;
    tick(3);
    bif.QD = 0;
    bif.LONG = 1;
    tick(2);
    check("pre_clr_W3", wv(), 32'd4);
    CLR = 0;
    tick(1);
    check("clr_W", wv(), 32'd0);
    check("clr_RUN", {31'd0, bif.RUN}, 32'd0);
    check("clr_CYC", {16'd0, bif.CYC}, 32'd0);
    bif.LONG = 0;
    CLR = 1;
    tick(5);
    check("post_clr_idle", {31'd0, bif.RUN}, 32'd0);

    if (CNT_EN) begin
      bif.QD = 1;
      tick(3);
      bif.QD = 0;
      bif.SHORT = 1;
      tick(65535);
      check("wrap_max_CYC", {16'd0, bif.CYC}, 32'h0000FFFF);
      tick(1);
      check("wrap_zero_CYC", {16'd0, bif.CYC}, 32'd0);
      bif.SHORT = 0;
      tick(2);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
